// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MEM pipeline stage: data-memory access over req/ack, load alignment, MEM/WB register
module mem_stage #(
    parameter int         ADDR_W   = 32,
    parameter logic [4:0] EXC_ADEL = 5'd4,
    parameter logic [4:0] EXC_ADES = 5'd5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        control_in,
    input  logic [31:0]       alu_in,
    input  logic [31:0]       sw_in,
    input  logic [4:0]        regdst_in,
    input  logic [4:0]        vector_ex_in,
    input  logic [31:0]       pc_in,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [3:0]        dmem_be,
    output logic [31:0]       dmem_wdata,
    input  logic              dmem_ack,
    input  logic [31:0]       dmem_rdata,
    output logic              mem_stall,
    output logic              wb_valid,
    output logic              wb_regwrite,
    output logic [4:0]        wb_regdst,
    output logic [31:0]       wb_data,
    output logic [4:0]        wb_vector,
    output logic [31:0]       wb_pc
);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t state, state_d;

    logic              nop, memread, memwrite, regwrite, memtoreg, load_unsigned;
    logic [1:0]        size;
    logic              is_word, is_half, is_byte;
    logic              memop, misalign, access;
    logic [4:0]        final_vec;
    logic [31:0]       lane, load_data;

    logic              req_d, we_d;
    logic [ADDR_W-1:0] addr_d;
    logic [3:0]        be_d;
    logic [31:0]       wdata_d;
    logic              wb_valid_d, wb_regwrite_d;
    logic [4:0]        wb_regdst_d, wb_vector_d;
    logic [31:0]       wb_data_d, wb_pc_d;

    assign nop           = control_in[0];
    assign memread       = control_in[1];
    assign memwrite      = control_in[2];
    assign regwrite      = control_in[3];
    assign memtoreg      = control_in[4];
    assign size          = control_in[6:5];
    assign load_unsigned = control_in[7];

    // Reserved size encoding 11 behaves as a word access.
    assign is_half  = (size == 2'b01);
    assign is_byte  = (size == 2'b10);
    assign is_word  = ~is_half & ~is_byte;

    assign memop    = ~nop & (memread | memwrite);
    assign misalign = (is_half & alu_in[0]) | (is_word & (alu_in[1:0] != 2'b00));
    assign access   = memop & (vector_ex_in == 5'd0) & ~misalign;

    always_comb begin
        final_vec = 5'd0;
        if (nop)
            final_vec = 5'd0;
        else if (vector_ex_in != 5'd0)
            final_vec = vector_ex_in;
        else if (memop & misalign)
            final_vec = memwrite ? EXC_ADES : EXC_ADEL;
    end

    assign lane = dmem_rdata >> {alu_in[1:0], 3'b000};

    always_comb begin
        load_data = dmem_rdata;
        if (is_byte)
            load_data = load_unsigned ? {24'd0, lane[7:0]} : {{24{lane[7]}}, lane[7:0]};
        else if (is_half)
            load_data = load_unsigned ? {16'd0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
    end

    always_comb begin
        state_d       = state;
        mem_stall     = 1'b0;
        req_d         = dmem_req;
        we_d          = dmem_we;
        addr_d        = dmem_addr;
        be_d          = dmem_be;
        wdata_d       = dmem_wdata;
        wb_valid_d    = wb_valid;
        wb_regwrite_d = wb_regwrite;
        wb_regdst_d   = wb_regdst;
        wb_data_d     = wb_data;
        wb_vector_d   = wb_vector;
        wb_pc_d       = wb_pc;
        case (state)
            S_IDLE: begin
                if (access) begin
                    mem_stall     = 1'b1;
                    state_d       = S_WAIT;
                    req_d         = 1'b1;
                    we_d          = memwrite;
                    addr_d        = {alu_in[ADDR_W-1:2], 2'b00};
                    if (is_byte) begin
                        be_d    = 4'b0001 << alu_in[1:0];
                        wdata_d = {4{sw_in[7:0]}};
                    end else if (is_half) begin
                        be_d    = 4'b0011 << alu_in[1:0];
                        wdata_d = {2{sw_in[15:0]}};
                    end else begin
                        be_d    = 4'b1111;
                        wdata_d = sw_in;
                    end
                    wb_valid_d    = 1'b0;
                    wb_regwrite_d = 1'b0;
                    wb_vector_d   = 5'd0;
                end else begin
                    wb_valid_d    = ~nop;
                    wb_regwrite_d = regwrite & ~nop & (final_vec == 5'd0);
                    wb_regdst_d   = regdst_in;
                    wb_data_d     = alu_in;
                    wb_vector_d   = final_vec;
                    wb_pc_d       = pc_in;
                end
            end
            S_WAIT: begin
                // The EX/MEM bundle is frozen by mem_stall, so alu_in/control_in still describe this access.
                mem_stall     = ~dmem_ack;
                wb_valid_d    = 1'b0;
                wb_regwrite_d = 1'b0;
                if (dmem_ack) begin
                    state_d       = S_IDLE;
                    req_d         = 1'b0;
                    wb_valid_d    = 1'b1;
                    wb_regwrite_d = regwrite;
                    wb_regdst_d   = regdst_in;
                    wb_data_d     = memtoreg ? load_data : alu_in;
                    wb_vector_d   = 5'd0;
                    wb_pc_d       = pc_in;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dmem_req    <= 1'b0;
            dmem_we     <= 1'b0;
            dmem_addr   <= '0;
            dmem_be     <= 4'd0;
            dmem_wdata  <= 32'd0;
            wb_valid    <= 1'b0;
            wb_regwrite <= 1'b0;
            wb_regdst   <= 5'd0;
            wb_data     <= 32'd0;
            wb_vector   <= 5'd0;
            wb_pc       <= 32'd0;
        end else begin
            dmem_req    <= req_d;
            dmem_we     <= we_d;
            dmem_addr   <= addr_d;
            dmem_be     <= be_d;
            dmem_wdata  <= wdata_d;
            wb_valid    <= wb_valid_d;
            wb_regwrite <= wb_regwrite_d;
            wb_regdst   <= wb_regdst_d;
            wb_data     <= wb_data_d;
            wb_vector   <= wb_vector_d;
            wb_pc       <= wb_pc_d;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - self-checking bench for mem_stage: vector table, reset corner, randomized model check
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  control_in = 8'd0;
    logic [31:0] alu_in = 32'd0;
    logic [31:0] sw_in = 32'd0;
    logic [4:0]  regdst_in = 5'd0;
    logic [4:0]  vector_ex_in = 5'd0;
    logic [31:0] pc_in = 32'd0;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ack = 1'b0;
    logic [31:0] dmem_rdata = 32'd0;
    logic        mem_stall;
    logic        wb_valid, wb_regwrite;
    logic [4:0]  wb_regdst, wb_vector;
    logic [31:0] wb_data, wb_pc;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk(clk), .reset(reset), .control_in(control_in), .alu_in(alu_in), .sw_in(sw_in),
        .regdst_in(regdst_in), .vector_ex_in(vector_ex_in), .pc_in(pc_in),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
        .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .mem_stall(mem_stall), .wb_valid(wb_valid), .wb_regwrite(wb_regwrite),
        .wb_regdst(wb_regdst), .wb_data(wb_data), .wb_vector(wb_vector), .wb_pc(wb_pc)
    );

    typedef struct {
        logic [7:0]  ctrl;
        logic [31:0] alu;
        logic [31:0] sw;
        logic [4:0]  rd;
        logic [4:0]  vec;
        logic [31:0] pc;
        int          delay;
        logic [31:0] rdata;
        int          stall;
        bit          acc;
        bit          we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        bit          valid;
        bit          regwrite;
        logic [31:0] data;
        logic [4:0]  vector;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference behaviour from the access rules: byte count, offset, lane masks.
    function automatic vec_t model(input vec_t v);
        vec_t        r;
        int          n, off;
        bit          nop, rdq, wrq, memop, misal;
        logic [4:0]  fv;
        logic [31:0] mask, val;
        r = v;
        nop = v.ctrl[0]; rdq = v.ctrl[1]; wrq = v.ctrl[2];
        n = (v.ctrl[6:5] == 2'b01) ? 2 : (v.ctrl[6:5] == 2'b10) ? 1 : 4;
        off = int'(v.alu % 4);
        memop = !nop && (rdq || wrq);
        misal = (v.alu % n) != 0;
        if (nop) fv = 5'd0;
        else if (v.vec != 0) fv = v.vec;
        else if (memop && misal) fv = wrq ? 5'd5 : 5'd4;
        else fv = 5'd0;
        r.acc   = memop && v.vec == 0 && !misal;
        r.stall = r.acc ? v.delay + 1 : 0;
        r.we    = wrq;
        r.addr  = v.alu - off;
        r.be    = 4'(((1 << n) - 1) << off);
        for (int i = 0; i < 4; i++) r.wdata[8*i +: 8] = v.sw[8*(i % n) +: 8];
        if (r.acc) begin
            r.valid = 1; r.regwrite = v.ctrl[3]; r.vector = 0;
            val = v.rdata >> (8 * off);
            if (n < 4) begin
                mask = (32'd1 << (8 * n)) - 1;
                val = val & mask;
                if (!v.ctrl[7] && val[8*n-1]) val = val | ~mask;
            end
            r.data = v.ctrl[4] ? val : v.alu;
        end else begin
            r.valid = !nop; r.regwrite = v.ctrl[3] && !nop && fv == 0;
            r.data = v.alu; r.vector = fv;
        end
        return r;
    endfunction

    // Present one EX/MEM bundle, act as the memory, hold it while stalled, then check MEM/WB.
    task automatic apply(input vec_t v, input string tag);
        int stalls = 0;
        int waited = 0;
        bit done = 0;
        bit saw_req = 0;
        control_in = v.ctrl; alu_in = v.alu; sw_in = v.sw; regdst_in = v.rd;
        vector_ex_in = v.vec; pc_in = v.pc;
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            @(negedge clk);
            if (dmem_req) begin
                saw_req = 1;
                chk({tag, ".addr"}, dmem_addr, v.addr);
                chk({tag, ".be"}, {28'd0, dmem_be}, {28'd0, v.be});
                chk({tag, ".we"}, {31'd0, dmem_we}, {31'd0, v.we});
                chk({tag, ".wdata"}, dmem_wdata, v.wdata);
                chk({tag, ".wait_wb_valid"}, {31'd0, wb_valid}, 32'd0);
                if (waited == v.delay) begin
                    dmem_ack = 1'b1; dmem_rdata = v.rdata;
                end else begin
                    waited++;
                end
            end
            #1;
            if (mem_stall) stalls++; else done = 1;
            @(posedge clk); #1;
            dmem_ack = 1'b0; dmem_rdata = $urandom;
        end
        chk({tag, ".timeout"}, {31'd0, done}, 32'd1);
        chk({tag, ".stalls"}, stalls, v.stall);
        chk({tag, ".req_seen"}, {31'd0, saw_req}, {31'd0, v.acc});
        chk({tag, ".wb_valid"}, {31'd0, wb_valid}, {31'd0, v.valid});
        chk({tag, ".wb_regwrite"}, {31'd0, wb_regwrite}, {31'd0, v.regwrite});
        chk({tag, ".wb_vector"}, {27'd0, wb_vector}, {27'd0, v.vector});
        chk({tag, ".wb_data"}, wb_data, v.data);
        chk({tag, ".wb_pc"}, wb_pc, v.pc);
        if (v.valid) chk({tag, ".wb_regdst"}, {27'd0, wb_regdst}, {27'd0, v.rd});
    endtask

    vec_t table_v[11];
    vec_t rv;

    initial begin
        table_v[0]  = '{8'h08, 32'h0000DEAD, 32'h0, 5'd1, 5'd0, 32'h100, 0, 32'h0, 0, 0, 0, 32'h0, 4'h0, 32'h0, 1, 1, 32'h0000DEAD, 5'd0};
        table_v[1]  = '{8'h5A, 32'h00001003, 32'h0, 5'd3, 5'd0, 32'h104, 2, 32'h80FF0000, 3, 1, 0, 32'h1000, 4'h8, 32'h0, 1, 1, 32'hFFFFFF80, 5'd0};
        table_v[2]  = '{8'hDA, 32'h00001003, 32'h0, 5'd3, 5'd0, 32'h108, 2, 32'h80FF0000, 3, 1, 0, 32'h1000, 4'h8, 32'h0, 1, 1, 32'h00000080, 5'd0};
        table_v[3]  = '{8'h24, 32'h00002002, 32'h1234ABCD, 5'd0, 5'd0, 32'h10C, 0, 32'h0, 1, 1, 1, 32'h2000, 4'hC, 32'hABCDABCD, 1, 0, 32'h00002002, 5'd0};
        table_v[4]  = '{8'h1A, 32'h00000006, 32'h0, 5'd4, 5'd0, 32'h110, 0, 32'h0, 0, 0, 0, 32'h0, 4'h0, 32'h0, 1, 0, 32'h00000006, 5'd4};
        table_v[5]  = '{8'h04, 32'h00003000, 32'h55, 5'd5, 5'd12, 32'h114, 0, 32'h0, 0, 0, 0, 32'h0, 4'h0, 32'h0, 1, 0, 32'h00003000, 5'd12};
        table_v[6]  = '{8'h03, 32'h00004000, 32'h0, 5'd6, 5'd0, 32'h118, 0, 32'h0, 0, 0, 0, 32'h0, 4'h0, 32'h0, 0, 0, 32'h00004000, 5'd0};
        table_v[7]  = '{8'h26, 32'h00000001, 32'h0, 5'd7, 5'd0, 32'h11C, 0, 32'h0, 0, 0, 0, 32'h0, 4'h0, 32'h0, 1, 0, 32'h00000001, 5'd5};
        table_v[8]  = '{8'h08, 32'h00000077, 32'h0, 5'd8, 5'd0, 32'h120, 0, 32'h0, 0, 0, 0, 32'h0, 4'h0, 32'h0, 1, 1, 32'h00000077, 5'd0};
        table_v[9]  = '{8'h1A, 32'h00005004, 32'h11111111, 5'd9, 5'd0, 32'h124, 1, 32'hCAFEBABE, 2, 1, 0, 32'h5004, 4'hF, 32'h11111111, 1, 1, 32'hCAFEBABE, 5'd0};
        table_v[10] = '{8'h08, 32'h00000088, 32'h0, 5'd10, 5'd0, 32'h128, 0, 32'h0, 0, 0, 0, 32'h0, 4'h0, 32'h0, 1, 1, 32'h00000088, 5'd0};

        #12;
        chk("reset.dmem_req", {31'd0, dmem_req}, 32'd0);
        chk("reset.dmem_be", {28'd0, dmem_be}, 32'd0);
        chk("reset.dmem_addr", dmem_addr, 32'd0);
        chk("reset.wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("reset.wb_pc", wb_pc, 32'd0);
        chk("reset.wb_data", wb_data, 32'd0);
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 11; i++) apply(table_v[i], $sformatf("vec%0d", i));

        // Reset during WAIT: request drops without a clock edge, late ack is ignored.
        control_in = 8'h1A; alu_in = 32'h10; vector_ex_in = 5'd0; pc_in = 32'h200;
        @(posedge clk); #1;
        chk("rst_wait.req_before", {31'd0, dmem_req}, 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("rst_wait.req_async", {31'd0, dmem_req}, 32'd0);
        chk("rst_wait.wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("rst_wait.wb_pc", wb_pc, 32'd0);
        chk("rst_wait.wb_data", wb_data, 32'd0);
        control_in = 8'h01;
        @(negedge clk); reset = 1'b0; dmem_ack = 1'b1; dmem_rdata = 32'h12345678;
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        chk("rst_wait.late_ack_valid", {31'd0, wb_valid}, 32'd0);
        chk("rst_wait.late_ack_req", {31'd0, dmem_req}, 32'd0);
        chk("rst_wait.idle_stall", {31'd0, mem_stall}, 32'd0);

        for (int i = 0; i < 200; i++) begin
            rv.ctrl  = 8'($urandom);
            rv.ctrl[0] = ($urandom_range(0, 7) == 0);
            rv.alu   = $urandom;
            rv.sw    = $urandom;
            rv.rd    = 5'($urandom);
            rv.vec   = ($urandom_range(0, 5) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
            rv.pc    = 32'h1000 + 32'(i * 4);
            rv.delay = $urandom_range(0, 3);
            rv.rdata = $urandom;
            rv = model(rv);
            apply(rv, $sformatf("rnd%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
